// File: rtl/tick_pkg.sv
// Shared types and constants for the game-tick receiver.
// Used by tick_receiver and bcd_counter.
package tick_pkg;

    localparam int BCD_W    = 4;
    localparam int PERIOD_W = 28;

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } tick_state_e;

endpackage

// File: rtl/tick_receiver_bcd_counter.sv
// Packed BCD up-counter with ripple carry between digits.
// TICK_SCORE_SATURATE_EN: hold at all nines instead of wrapping.
module bcd_counter
    import tick_pkg::*;
#(
    parameter int BCD_DIGITS = 4
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        inc,
    output logic [BCD_W*BCD_DIGITS-1:0] value
);

    logic [BCD_W*BCD_DIGITS-1:0] nxt;
    logic                        carry;
`ifdef TICK_SCORE_SATURATE_EN
    logic                        all_nines;
`endif

    always_comb begin
        nxt   = value;
        carry = inc;
`ifdef TICK_SCORE_SATURATE_EN
        all_nines = 1'b1;
`endif
        for (int i = 0; i < BCD_DIGITS; i++) begin
`ifdef TICK_SCORE_SATURATE_EN
            all_nines = all_nines & (value[i*BCD_W +: BCD_W] == 4'd9);
`endif
            if (carry) begin
                if (value[i*BCD_W +: BCD_W] == 4'd9) begin
                    nxt[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    nxt[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
`ifdef TICK_SCORE_SATURATE_EN
        end else if (!all_nines) begin
            value <= nxt;
`else
        end else begin
            value <= nxt;
`endif
        end
    end

endmodule

// File: rtl/tick_receiver.sv
// Game-tick receiver: sync, edge pulse, period watch, BCD score.
// TICK_SCORE_SATURATE_EN makes the score hold at all nines.
module tick_receiver
    import tick_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [PERIOD_W-1:0] TIMEOUT     = 28'd40000000,
    parameter int                  BCD_DIGITS  = 4
) (
    input  logic                        clock_in,
    input  logic                        reset,
    input  logic                        tick_in,
    input  logic                        run,
    input  logic                        clear,
    output logic                        tick_pulse,
    output logic [BCD_W*BCD_DIGITS-1:0] score_bcd,
    output logic [PERIOD_W-1:0]         period,
    output logic                        period_valid,
    output logic                        tick_lost
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   sync_out;
    logic [PERIOD_W-1:0]    cnt;
    logic [PERIOD_W-1:0]    period_next;
    logic                   timeout;
    logic                   score_inc;
    tick_state_e            state;

    assign sync_out    = sync[SYNC_STAGES-1];
    assign period_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 28'd1;
    assign timeout     = (cnt == TIMEOUT - 28'd1);
    assign score_inc   = tick_pulse & run & (state != LOST);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync         <= '0;
            prev         <= 1'b0;
            tick_pulse   <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            tick_lost    <= 1'b0;
            state        <= IDLE;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], tick_in};
            prev       <= sync_out;
            tick_pulse <= sync_out & ~prev;

            if (tick_pulse) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 28'd1;
            end

            // A pulse in the timeout cycle wins, so timeout is only
            // considered when no pulse is present.
            unique case (state)
                IDLE: begin
                    if (tick_pulse) state <= FIRST;
                end
                FIRST: begin
                    if (tick_pulse) begin
                        period       <= period_next;
                        period_valid <= 1'b1;
                        state        <= LOCKED;
                    end else if (timeout) begin
                        tick_lost <= 1'b1;
                        state     <= LOST;
                    end
                end
                LOCKED: begin
                    if (tick_pulse) begin
                        period <= period_next;
                    end else if (timeout) begin
                        tick_lost <= 1'b1;
                        state     <= LOST;
                    end
                end
                LOST: begin
                    if (clear) begin
                        tick_lost    <= 1'b0;
                        period_valid <= 1'b0;
                        state        <= IDLE;
                    end else if (tick_pulse) begin
                        tick_lost <= 1'b0;
                        state     <= FIRST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bcd_counter #(
        .BCD_DIGITS(BCD_DIGITS)
    ) u_score (
        .clock_in(clock_in),
        .reset   (reset),
        .clear   (clear),
        .inc     (score_inc),
        .value   (score_bcd)
    );

endmodule

// File: tb/tb_tick_receiver.sv
// Directed bench for tick_receiver (TIMEOUT=100, 2 digits, 2 sync stages).
// Expected values are hand-derived from negedge-sampled cycle counts.
module tb_tick_receiver;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        run;
    logic        clear;
    logic        tick_pulse;
    logic [7:0]  score_bcd;
    logic [27:0] period;
    logic        period_valid;
    logic        tick_lost;

    int total = 0;
    int bad   = 0;
    int np;
    int sum;
    logic [7:0] wrap_exp;

    always #5 clock_in = ~clock_in;

    tick_receiver #(
        .SYNC_STAGES(2),
        .TIMEOUT    (28'd100),
        .BCD_DIGITS (2)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .tick_in     (tick_in),
        .run         (run),
        .clear       (clear),
        .tick_pulse  (tick_pulse),
        .score_bcd   (score_bcd),
        .period      (period),
        .period_valid(period_valid),
        .tick_lost   (tick_lost)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick_in cycle; returns the number of sampled cycles with a pulse.
    task automatic tick(input int hi, input int lo, output int n);
        n = 0;
        tick_in = 1'b1;
        repeat (hi) begin
            @(negedge clock_in);
            if (tick_pulse) n++;
        end
        tick_in = 1'b0;
        repeat (lo) begin
            @(negedge clock_in);
            if (tick_pulse) n++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        tick_in = 1'b0;
        run     = 1'b0;
        clear   = 1'b0;
        step(3);
        chk("rst_pulse", {31'd0, tick_pulse}, 0);
        chk("rst_score", {24'd0, score_bcd}, 0);
        chk("rst_period", {4'd0, period}, 0);
        chk("rst_pvalid", {31'd0, period_valid}, 0);
        chk("rst_lost", {31'd0, tick_lost}, 0);
        reset = 1'b0;
        step(2);

        // First rise: pulse on the third sampled cycle, one wide.
        tick_in = 1'b1;
        step(2);
        chk("lat_early", {31'd0, tick_pulse}, 0);
        step(1);
        chk("lat3", {31'd0, tick_pulse}, 1);
        step(1);
        chk("width1", {31'd0, tick_pulse}, 0);
        step(16);
        tick_in = 1'b0;
        sum = 0;
        repeat (20) begin
            step(1);
            if (tick_pulse) sum++;
        end
        chk("no_fall_pulse", sum, 0);
        chk("pv_before", {31'd0, period_valid}, 0);
        tick_in = 1'b1;
        step(3);
        chk("pulse2", {31'd0, tick_pulse}, 1);
        step(1);
        chk("period40", {4'd0, period}, 40);
        chk("pv_after", {31'd0, period_valid}, 1);
        step(16);
        tick_in = 1'b0;
        step(20);

        // Score counts 12 edges, freezes with run low, then clears.
        run = 1'b1;
        sum = 0;
        repeat (12) begin
            tick(20, 20, np);
            sum += np;
        end
        chk("pulses12", sum, 12);
        chk("score12", {24'd0, score_bcd}, 32'h12);
        chk("period40b", {4'd0, period}, 40);
        chk("lost_locked", {31'd0, tick_lost}, 0);
        run = 1'b0;
        repeat (3) tick(20, 20, np);
        chk("score_frozen", {24'd0, score_bcd}, 32'h12);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("score_clr", {24'd0, score_bcd}, 0);

        // Timeout in LOCKED, then recovery through FIRST.
        run = 1'b1;
        tick_in = 1'b1;
        step(3);
        chk("pulse_pre_lost", {31'd0, tick_pulse}, 1);
        step(17);
        tick_in = 1'b0;
        step(83);
        chk("lost_early", {31'd0, tick_lost}, 0);
        step(1);
        chk("lost_set", {31'd0, tick_lost}, 1);
        chk("score_pre_lost", {24'd0, score_bcd}, 32'h01);
        tick_in = 1'b1;
        step(3);
        chk("pulse_in_lost", {31'd0, tick_pulse}, 1);
        step(1);
        chk("lost_cleared", {31'd0, tick_lost}, 0);
        chk("score_lost_edge", {24'd0, score_bcd}, 32'h01);
        chk("period_kept", {4'd0, period}, 41);
        chk("pv_kept", {31'd0, period_valid}, 1);
        step(11);
        tick_in = 1'b0;
        step(15);
        tick_in = 1'b1;
        step(3);
        step(1);
        chk("period30", {4'd0, period}, 30);
        chk("pv_relock", {31'd0, period_valid}, 1);
        chk("score_relock", {24'd0, score_bcd}, 32'h02);
        step(6);
        tick_in = 1'b0;
        step(10);

        // Count to 99, then one more edge.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        repeat (99) tick(10, 10, np);
        chk("score99", {24'd0, score_bcd}, 32'h99);
        chk("period20", {4'd0, period}, 20);
`ifdef TICK_SCORE_SATURATE_EN
        wrap_exp = 8'h99;
`else
        wrap_exp = 8'h00;
`endif
        tick(10, 10, np);
        chk("score_wrap", {24'd0, score_bcd}, {24'd0, wrap_exp});

        // Pulse and clear in the same cycle: clear wins.
        tick_in = 1'b1;
        step(3);
        chk("pulse_clr", {31'd0, tick_pulse}, 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("score_clr_win", {24'd0, score_bcd}, 0);
        step(6);
        tick_in = 1'b0;
        step(10);

        // Reset mid-period with score 37.
        repeat (37) tick(10, 10, np);
        chk("score37", {24'd0, score_bcd}, 32'h37);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mrst_score", {24'd0, score_bcd}, 0);
        chk("mrst_period", {4'd0, period}, 0);
        chk("mrst_pvalid", {31'd0, period_valid}, 0);
        chk("mrst_lost", {31'd0, tick_lost}, 0);
        chk("mrst_pulse", {31'd0, tick_pulse}, 0);
        step(50);
        tick_in = 1'b1;
        step(3);
        chk("post_rst_pulse", {31'd0, tick_pulse}, 1);
        step(1);
        chk("post_rst_pv", {31'd0, period_valid}, 0);
        chk("post_rst_period", {4'd0, period}, 0);
        chk("post_rst_score", {24'd0, score_bcd}, 32'h01);
        step(6);
        tick_in = 1'b0;
        step(10);
        tick_in = 1'b1;
        step(4);
        chk("post_rst_p20", {4'd0, period}, 20);
        chk("post_rst_pv1", {31'd0, period_valid}, 1);
        chk("post_rst_score2", {24'd0, score_bcd}, 32'h02);
        tick_in = 1'b0;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
